// File: rtl/freq_slew_if.sv
`default_nettype none
// ============================================================================
// Module   : freq_slew_if
// Brief    : Bus between the frequency slew controller and its environment.
//            Carries the link-alive flag, the PLL estimate, and the tracked
//            drive frequency with its update pulse and lock flag.
//            Macro FSLEW_FREEZE_EN adds the freeze request.
// Revision : 1.0 - initial release
// ============================================================================
interface freq_slew_if;
    logic        swiptAlive;
    logic [31:0] f_in;
    logic [31:0] freq;
    logic        freq_upd;
    logic        locked;
`ifdef FSLEW_FREEZE_EN
    logic        freeze;
`endif

    // Environment side: drives the inputs and observes the tracked outputs
    modport master (
        output swiptAlive,
        output f_in,
`ifdef FSLEW_FREEZE_EN
        output freeze,
`endif
        input  freq,
        input  freq_upd,
        input  locked
    );

    // Controller side
    modport slave (
        input  swiptAlive,
        input  f_in,
`ifdef FSLEW_FREEZE_EN
        input  freeze,
`endif
        output freq,
        output freq_upd,
        output locked
    );
endinterface
`default_nettype wire

// File: rtl/freq_slew_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : freq_slew_ctrl
// Brief    : Clamps the PLL2 frequency estimate to a legal band and slews the
//            SWIPT drive frequency toward it by a bounded step on every
//            update tick; flags lock after LOCK_CNT in-tolerance ticks.
//            Optional macro FSLEW_FREEZE_EN adds a freeze input that makes
//            the controller ignore ticks while asserted.
// Revision : 1.0 - initial release
// ============================================================================
module freq_slew_ctrl #(
    parameter logic [31:0] F_DEFAULT = 32'h9C40,
    parameter logic [31:0] F_MIN     = 32'd30000,
    parameter logic [31:0] F_MAX     = 32'd50000,
    parameter logic [31:0] STEP_MAX  = 32'h1F4,
    parameter int          UPD_DIV   = 1000,
    parameter logic [31:0] LOCK_TOL  = 32'd50,
    parameter int          LOCK_CNT  = 8
) (
    input  wire logic      clk,
    input  wire logic      rst,
    freq_slew_if.slave     bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_TRACK  = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    localparam int                 CNT_W    = $clog2(UPD_DIV);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(UPD_DIV - 1);
    localparam logic [7:0]         LCNT_SAT = 8'(LOCK_CNT);

    logic [1:0]       state_q, state_d;
    logic [31:0]      freq_q,  freq_d;
    logic             upd_q,   upd_d;
    logic [7:0]       lcnt_q,  lcnt_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic [31:0] w_tgt;
    logic [32:0] w_delta;
    logic [32:0] w_abs;
    logic [31:0] w_slew;
    logic        w_in_tol;
    logic        w_tick;
    logic        w_frozen;
    logic [7:0]  w_lcnt_inc;

`ifdef FSLEW_FREEZE_EN
    assign w_frozen = bus.freeze;
`else
    assign w_frozen = 1'b0;
`endif

    // Target clamp, signed distance to it, and the bounded slew step
    always_comb begin
        if (bus.f_in < F_MIN)      w_tgt = F_MIN;
        else if (bus.f_in > F_MAX) w_tgt = F_MAX;
        else                       w_tgt = bus.f_in;

        w_delta = {1'b0, w_tgt} - {1'b0, freq_q};
        w_abs   = w_delta[32] ? (~w_delta + 33'd1) : w_delta;

        if (w_abs <= {1'b0, STEP_MAX}) w_slew = w_tgt;
        else if (w_delta[32])          w_slew = freq_q - STEP_MAX;
        else                           w_slew = freq_q + STEP_MAX;

        w_in_tol   = (w_abs <= {1'b0, LOCK_TOL});
        w_tick     = (state_q != S_IDLE) && (cnt_q == CNT_LAST);
        w_lcnt_inc = (lcnt_q >= LCNT_SAT) ? LCNT_SAT : lcnt_q + 8'd1;
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            freq_q  <= F_DEFAULT;
            upd_q   <= 1'b0;
            lcnt_q  <= 8'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            freq_q  <= freq_d;
            upd_q   <= upd_d;
            lcnt_q  <= lcnt_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: link loss forces the idle defaults; otherwise slew on ticks
    always_comb begin
        state_d = state_q;
        freq_d  = freq_q;
        upd_d   = 1'b0;
        lcnt_d  = lcnt_q;
        cnt_d   = cnt_q;
        if (!bus.swiptAlive) begin
            state_d = S_IDLE;
            freq_d  = F_DEFAULT;
            lcnt_d  = 8'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_TRACK;
                    freq_d  = F_DEFAULT;
                    cnt_d   = '0;
                end
                default: begin
                    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
                    if (w_tick && !w_frozen) begin
                        if (bus.f_in == 32'd0) begin
                            // Invalid estimate: hold frequency, drop any lock
                            lcnt_d  = 8'd0;
                            state_d = S_TRACK;
                        end else begin
                            freq_d = w_slew;
                            upd_d  = (w_slew != freq_q);
                            if (w_in_tol) begin
                                lcnt_d = w_lcnt_inc;
                                if (w_lcnt_inc == LCNT_SAT) state_d = S_LOCKED;
                            end else begin
                                lcnt_d  = 8'd0;
                                state_d = S_TRACK;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // Outputs are straight from registers, so freq and freq_upd move together
    always_comb begin
        bus.freq     = freq_q;
        bus.freq_upd = upd_q;
        bus.locked   = (state_q == S_LOCKED);
    end

endmodule
`default_nettype wire

// File: tb/tb_freq_slew_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_freq_slew_ctrl
// Brief    : Directed self-checking bench for freq_slew_ctrl with a short
//            update divider; freeze steps build only with FSLEW_FREEZE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_freq_slew_ctrl;

    localparam int DIV = 4;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    freq_slew_if bus ();

    freq_slew_ctrl #(
        .UPD_DIV (DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 ns past the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst            = 1'b1;
        bus.swiptAlive = 1'b0;
        bus.f_in       = 32'd0;
`ifdef FSLEW_FREEZE_EN
        bus.freeze     = 1'b0;
`endif

        // Reset state
        step(3);
        chk("rst_freq",   bus.freq,     32'd40000);
        chk("rst_upd",    bus.freq_upd, 32'd0);
        chk("rst_locked", bus.locked,   32'd0);
        rst = 1'b0;
        bus.f_in = 32'd42000;
        step(6);
        chk("idle_freq", bus.freq, 32'd40000);

        // Acquire 42000: four slew steps, then eight in-tolerance ticks
        bus.swiptAlive = 1'b1;
        step(1);
        for (int k = 1; k <= 4; k++) begin
            step(DIV - 1);
            chk("pre_tick_upd", bus.freq_upd, 32'd0);
            step(1);
            chk("slew_freq", bus.freq, 32'd40000 + 32'(k) * 32'd500);
            chk("slew_upd",  bus.freq_upd, 32'd1);
        end
        for (int k = 5; k <= 11; k++) begin
            step(DIV);
            chk("settle_locked", bus.locked,   32'd0);
            chk("settle_upd",    bus.freq_upd, 32'd0);
        end
        step(DIV);
        chk("lock_t12", bus.locked, 32'd1);
        chk("lock_freq", bus.freq,  32'd42000);

        // Loss of lock and the new step on the same edge
        bus.f_in = 32'd41000;
        step(DIV);
        chk("unlock_locked", bus.locked,   32'd0);
        chk("unlock_freq",   bus.freq,     32'd41500);
        chk("unlock_upd",    bus.freq_upd, 32'd1);
        step(DIV);
        chk("down_freq", bus.freq, 32'd41000);

        // Upper clamp
        bus.f_in = 32'd60000;
        for (int k = 0; k < 20; k++) begin
            step(DIV);
            chk("band_hi", 32'(bus.freq <= 32'd50000), 32'd1);
        end
        chk("clamp_hi_freq", bus.freq,     32'd50000);
        chk("clamp_hi_upd",  bus.freq_upd, 32'd0);

        // Lower clamp
        bus.f_in = 32'd20000;
        for (int k = 0; k < 42; k++) begin
            step(DIV);
            chk("band_lo", 32'(bus.freq >= 32'd30000), 32'd1);
        end
        chk("clamp_lo_freq", bus.freq, 32'd30000);

        // Link drop mid-count applies idle defaults without a pulse
        bus.f_in = 32'd35000;
        step(2 * DIV);
        chk("mid_freq", bus.freq, 32'd31000);
        step(2);
        bus.swiptAlive = 1'b0;
        step(1);
        chk("drop_freq",   bus.freq,     32'd40000);
        chk("drop_upd",    bus.freq_upd, 32'd0);
        chk("drop_locked", bus.locked,   32'd0);
        step(3 * DIV);
        chk("drop_hold", bus.freq, 32'd40000);

        // Invalid estimate holds frequency
        bus.f_in = 32'd42000;
        bus.swiptAlive = 1'b1;
        step(1 + DIV);
        chk("restart_freq", bus.freq,     32'd40500);
        chk("restart_upd",  bus.freq_upd, 32'd1);
        bus.f_in = 32'd0;
        step(DIV);
        chk("zero_freq", bus.freq,     32'd40500);
        chk("zero_upd",  bus.freq_upd, 32'd0);

        // Lock at F in place, saturate, then drop lock on an invalid estimate
        bus.f_in = 32'd40500;
        for (int k = 1; k <= 7; k++) begin
            step(DIV);
            chk("relock_wait", bus.locked, 32'd0);
        end
        step(DIV);
        chk("relock", bus.locked, 32'd1);
        step(DIV);
        chk("lock_sat", bus.locked, 32'd1);
        bus.f_in = 32'd0;
        step(DIV);
        chk("zero_unlock", bus.locked,   32'd0);
        chk("zero_hold",   bus.freq,     32'd40500);
        chk("zero_noupd",  bus.freq_upd, 32'd0);

`ifdef FSLEW_FREEZE_EN
        // Frozen ticks hold everything; release resumes slewing
        bus.f_in   = 32'd45000;
        bus.freeze = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(DIV);
            chk("frz_freq", bus.freq,     32'd40500);
            chk("frz_upd",  bus.freq_upd, 32'd0);
        end
        bus.freeze = 1'b0;
        step(DIV);
        chk("thaw_freq", bus.freq,     32'd41000);
        chk("thaw_upd",  bus.freq_upd, 32'd1);
`endif

        // Reset dominates a live link
        bus.f_in = 32'd45000;
        rst = 1'b1;
        step(1);
        chk("rst_win_freq",   bus.freq,   32'd40000);
        chk("rst_win_locked", bus.locked, 32'd0);
        step(DIV + 1);
        chk("rst_hold_freq", bus.freq, 32'd40000);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
